// File: rtl/arb_weight_credit_pkg.sv
// Shared definitions for the weighted-credit arbiter: default widths and FSM encoding.
package arb_weight_credit_pkg;

  localparam int unsigned ARB_REQ_NUM_DEF  = 3;
  localparam int unsigned ARB_WEIGHT_W_DEF = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_credit_cell.sv
// Single-requester credit counter: load, saturating decrement, underflow flag.
module arb_credit_cell
  import arb_weight_credit_pkg::*;
#(
  parameter int unsigned P_W = ARB_WEIGHT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [P_W-1:0] load_val_i,
  input  logic           dec_i,
  output logic [P_W-1:0] credit_o,
  output logic           remain_o,
  output logic           underflow_o
);

  logic [P_W-1:0] credit_q;
  logic [P_W-1:0] credit_d;

  always_comb begin
    credit_d = credit_q;
    if (load_i) begin
      credit_d = load_val_i;
    end else if (dec_i && (credit_q != '0)) begin
      credit_d = credit_q - P_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  // A grant landing on an empty counter is a protocol error; the counter never wraps.
  assign underflow_o = dec_i && (credit_q == '0);
  assign remain_o    = (credit_q > P_W'(1));
  assign credit_o    = credit_q;

endmodule

// File: rtl/arb_weight_credit.sv
// Per-requester credit bookkeeping for a weighted round-robin arbiter, with
// shadowed weight updates applied at round boundaries and a sticky error flag.
module arb_weight_credit
  import arb_weight_credit_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = ARB_REQ_NUM_DEF,
  parameter int unsigned P_WEIGHT_W      = ARB_WEIGHT_W_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] cfg_weight_i,
  input  logic                                  cfg_update_i,
  input  logic [P_REQUESTER_NUM-1:0]            grant_i,
  input  logic                                  grant_valid_i,
  input  logic                                  round_comp_i,
  output logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] credit_o,
  output logic [P_REQUESTER_NUM-1:0]            credit_remain_o,
  output logic                                  credit_valid_o,
  output logic                                  err_o
);

  localparam int unsigned NW = P_REQUESTER_NUM * P_WEIGHT_W;

  arb_state_e state_q, state_d;

  logic [NW-1:0]              active_q, active_d;
  logic [NW-1:0]              shadow_q, shadow_d;
  logic                       pending_q, pending_d;
  logic                       err_q, err_d;
  logic [NW-1:0]              credit_flat;
  logic [NW-1:0]              reload_val;
  logic [NW-1:0]              load_val;
  logic [P_REQUESTER_NUM-1:0] underflow;
  logic                       is_init, is_run;
  logic                       grant_onehot, grant_ok, grant_bad;
  logic                       reload_round, reload_auto, reload, load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a single INIT cycle, then RUN until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    is_init        = (state_q == ST_INIT);
    is_run         = (state_q == ST_RUN);
    credit_valid_o = is_run;
  end

  assign grant_onehot = $onehot(grant_i);
  assign grant_ok     = is_run && grant_valid_i && grant_onehot;
  assign grant_bad    = is_run && grant_valid_i && !grant_onehot;
  assign reload_round = grant_ok && round_comp_i;
  assign reload_auto  = is_run && !grant_valid_i && (credit_flat == '0);
  assign reload       = reload_round || reload_auto;
  assign load         = is_init || reload;

  // A same-cycle update beats a pending shadow, which beats the active set.
  assign reload_val = cfg_update_i ? cfg_weight_i : (pending_q ? shadow_q : active_q);
  assign load_val   = is_init ? cfg_weight_i : reload_val;

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = err_q || grant_bad || (|underflow);
    if (cfg_update_i) begin
      shadow_d  = cfg_weight_i;
      pending_d = 1'b1;
    end
    if (load) begin
      active_d  = load_val;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  for (genvar gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_cell
    arb_credit_cell #(
      .P_W (P_WEIGHT_W)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .load_val_i  (load_val[gi*P_WEIGHT_W +: P_WEIGHT_W]),
      .dec_i       (grant_ok && grant_i[gi]),
      .credit_o    (credit_flat[gi*P_WEIGHT_W +: P_WEIGHT_W]),
      .remain_o    (credit_remain_o[gi]),
      .underflow_o (underflow[gi])
    );
  end

  assign credit_o = credit_flat;
  assign err_o    = err_q;

endmodule

// File: doc/arb_weight_credit.md
ARB_WEIGHT_CREDIT -- requirements
Module: arb_weight_credit

Interface
REQ-001 P_REQUESTER_NUM, default 3, number of requesters (N).
REQ-002 P_WEIGHT_W, default 2, width of one weight/credit field (W).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_weight_i  input  N*W  configured weight per requester, indexed [0:N*W-1], requester n at bits [n*W +: W].
REQ-006 cfg_update_i  input  1  one-cycle pulse: new cfg_weight_i is to be applied.
REQ-007 grant_i  input  N  one-hot grant from arbiter, bit n = requester n.
REQ-008 grant_valid_i  input  1  grant_i is accepted this cycle.
REQ-009 round_comp_i  input  1  round-complete flag from the completion detector, same cycle as the final grant.
REQ-010 credit_o  output  N*W  current remaining credit per requester, same packing as cfg_weight_i; feeds the detector weight input.
REQ-011 credit_remain_o  output  N  bit n = credit of requester n greater than 1.
REQ-012 credit_valid_o  output  1  high in RUN state only.
REQ-013 err_o  output  1  sticky protocol-error flag.

Function
REQ-014 State machine SHALL have states INIT and RUN; INIT -> RUN unconditionally after one cycle; RUN -> INIT never except by reset.
REQ-015 In INIT every credit SHALL load cfg_weight_i; credit_valid_o = 0.
REQ-016 In RUN, on grant_valid_i with one-hot grant_i bit n and credit n > 0, credit n SHALL decrement by 1 in the next cycle; other credits hold.
REQ-017 On grant_valid_i & round_comp_i in RUN, all credits SHALL reload from the active weight set next cycle, overriding the decrement.
REQ-018 Active weight set: captured from cfg_weight_i in INIT; on cfg_update_i a shadow copy SHALL be captured and a pending flag set; pending shadow SHALL become active at the next reload, then pending clears.
REQ-019 cfg_update_i in the same cycle as a reload SHALL apply the new cfg_weight_i to that reload directly.
REQ-020 If all credits are 0 in RUN with no grant, credits SHALL auto-reload next cycle (exhaustion recovery).
REQ-021 round_comp_i without grant_valid_i SHALL be ignored.
REQ-022 Grant to a requester with credit 0 SHALL set err_o; credit stays 0 (no wrap).
REQ-023 grant_valid_i with grant_i zero or multi-bit SHALL set err_o; no credit changes.
REQ-024 credit_remain_o and credit_o SHALL be registered-state derived, no combinational path from grant inputs.
REQ-025 Credits SHALL be unsigned W-bit; weight 0 means requester never credited.

Reset
REQ-026 rst_n low SHALL asynchronously force: state INIT, all credits 0, active/shadow weights 0, pending 0, err_o 0, credit_valid_o 0, credit_remain_o 0.
REQ-027 Reset asserted mid-round SHALL discard all credits; after release one INIT cycle reloads from cfg_weight_i.
REQ-028 err_o SHALL clear only on reset.

Structure
REQ-029 State encoding (INIT, RUN) and default widths SHALL live in the shared arbiter package.
REQ-030 One sub-module is natural: arb_credit_cell (single requester counter with load/decrement/underflow flag), instantiated N times via generate.

Verification (N=3, W=2)
REQ-031 Reset release, cfg_weight={2,1,3} -> cycle 1 INIT, cycle 2 credit_o={2,1,3}, credit_valid_o=1, credit_remain_o=3'b101.
REQ-032 Grants 0,2,0,2,1(+round_comp_i),2 with the final 2 reached via reload sequence -> credits {1,1,3},{1,1,2},{0,1,2},{0,1,1},reload {2,1,3}; err_o=0.
REQ-033 cfg_update_i with {1,1,1} mid-round -> credits unchanged until round_comp_i grant, then {1,1,1}.
REQ-034 Grant to requester with credit 0 -> err_o=1 next cycle, credit stays 0, remains 1 until reset.
REQ-035 grant_i=3'b011 with grant_valid_i -> err_o=1, credits unchanged.
REQ-036 Weights {0,0,0} -> credits 0, auto-reload each cycle, credit_remain_o=0, no err_o.
